// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch (IF)
// and the data port (DM). DM wins contention unless IF has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] lat_cnt;
    logic       own_dm;
    logic       own_we;
    logic       grant;
    logic       grant_dm;

    // DM keeps priority until IF has lost STARVE_LIM contested rounds
    always_comb begin
        grant    = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if (dm_req && (!if_req || starve_cnt < STARVE_LIM)) begin
                grant    = 1'b1;
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = (own_dm && own_we) ? RESP : WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            own_dm     <= 1'b0;
            own_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        // mem_addr/mem_wdata double as the latched request
                        own_dm   <= grant_dm;
                        own_we   <= grant_dm & dm_we;
                        mem_en   <= 1'b1;
                        mem_we   <= grant_dm & dm_we;
                        mem_addr <= grant_dm ? dm_addr : if_addr;
                        if (grant_dm) mem_wdata <= dm_wdata;
                        if (!grant_dm)
                            starve_cnt <= '0;
                        else if (if_req)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ISSUE: begin
                    if (own_dm && own_we) dm_ready <= 1'b1;
                    else                  lat_cnt  <= LAT_INIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        if (own_dm) begin
                            dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule
